// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg: GF(2^8) arithmetic shared by the RS decoder stages.
//   Field polynomial x^8+x^4+x^3+x^2+1 (0x11D), primitive element alpha=0x02.
//   gf_mul       : generic 8x8 field multiply
//   gf_mul_const : multiply by a constant (folds to XOR network)
//   gf_inv_calc  : inverse as a^254 (inv(0)=0), used to build the inverse table
//   state_e      : one-hot Chien/Forney FSM encoding
package rs_gf_pkg;

  localparam logic [8:0] POLY       = 9'h11D;
  localparam logic [7:0] ALPHA      = 8'h02;
  localparam logic [7:0] ALPHA_INV  = 8'h8E;
  localparam logic [7:0] ALPHA_INV2 = 8'h47;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SCAN = 3'b010,
    ST_DONE = 3'b100
  } state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ POLY[7:0]) : (aa << 1);
    end
    return p;
  endfunction

  // Second operand is expected to be a constant so the shift/XOR chain
  // collapses to a fixed XOR matrix.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
    return gf_mul(a, c);
  endfunction

  // a^254 = a^(2+4+...+128); gives 0 for a=0.
  function automatic logic [7:0] gf_inv_calc(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// gf256_inv: combinational GF(2^8) inverse through a 256-entry constant table.
//   a_i   : field element
//   inv_o : a_i^-1, with 0 mapping to 0
module gf256_inv
  import rs_gf_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] inv_o
);

  logic [7:0] lut [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_lut
    assign lut[gi] = gf_inv_calc(8'(gi));
  end

  assign inv_o = lut[a_i];

endmodule

// File: rtl/s3_chien_forney.sv
// s3_chien_forney: serial Chien search + Forney magnitude for RS t=2 over GF(2^8).
//   clk, rstn          : clock, asynchronous active-low reset
//   kes_done           : load strobe, lambda/omega valid in the same cycle
//   rs_lambda0..2      : error-locator coefficients
//   rs_omega0..1       : error-evaluator coefficients
//   chien_busy         : high while a word is being scanned (through DONE)
//   err_valid/pos/val  : one pulse per located root with position and magnitude
//   chien_done         : one-cycle completion pulse, err_cnt/dec_fail valid
//   err_cnt, dec_fail  : roots found (saturating at 3), uncorrectable flag
module s3_chien_forney
  import rs_gf_pkg::*;
#(
  parameter int N = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       kes_done,
  input  logic [7:0] rs_lambda0,
  input  logic [7:0] rs_lambda1,
  input  logic [7:0] rs_lambda2,
  input  logic [7:0] rs_omega0,
  input  logic [7:0] rs_omega1,
  output logic       chien_busy,
  output logic       err_valid,
  output logic [7:0] err_pos,
  output logic [7:0] err_val,
  output logic       chien_done,
  output logic [1:0] err_cnt,
  output logic       dec_fail
);

  localparam logic [7:0] LAST_POS = 8'(N - 1);

  state_e     state_q;
  logic [7:0] pos_q;
  logic [7:0] t1_q, t2_q, w1_q, x_q;
  logic [7:0] lam0_q, om0_q, inv1_q;
  logic [1:0] deg_q, roots_q;
  logic       busy_q, err_valid_q, done_q, dec_fail_q;
  logic [7:0] err_pos_q, err_val_q;
  logic [1:0] err_cnt_q;

  logic [7:0] inv_lam1;
  logic [7:0] sum;
  logic [7:0] forney_a;
  logic [7:0] forney_e;
  logic [1:0] deg_in;

  gf256_inv u_inv (
    .a_i   (rs_lambda1),
    .inv_o (inv_lam1)
  );

  // T1/T2 hold lambda1*a^-i and lambda2*a^-2i, so the sum is Lambda(a^-i).
  assign sum = lam0_q ^ t1_q ^ t2_q;

  // Lambda'(x)=lambda1 in characteristic 2, so Forney is X*Omega(a^-i)/lambda1.
  assign forney_a = gf_mul(x_q, om0_q ^ w1_q);
  assign forney_e = gf_mul(forney_a, inv1_q);

  assign deg_in = (rs_lambda2 != 8'h00) ? 2'd2 :
                  (rs_lambda1 != 8'h00) ? 2'd1 : 2'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pos_q       <= 8'h00;
      t1_q        <= 8'h00;
      t2_q        <= 8'h00;
      w1_q        <= 8'h00;
      x_q         <= 8'h00;
      lam0_q      <= 8'h00;
      om0_q       <= 8'h00;
      inv1_q      <= 8'h00;
      deg_q       <= 2'd0;
      roots_q     <= 2'd0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_pos_q   <= 8'h00;
      err_val_q   <= 8'h00;
      done_q      <= 1'b0;
      err_cnt_q   <= 2'd0;
      dec_fail_q  <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      err_pos_q   <= 8'h00;
      err_val_q   <= 8'h00;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (kes_done) begin
            t1_q       <= rs_lambda1;
            t2_q       <= rs_lambda2;
            w1_q       <= rs_omega1;
            x_q        <= 8'h01;
            pos_q      <= 8'h00;
            lam0_q     <= rs_lambda0;
            om0_q      <= rs_omega0;
            inv1_q     <= inv_lam1;
            deg_q      <= deg_in;
            roots_q    <= 2'd0;
            err_cnt_q  <= 2'd0;
            dec_fail_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (sum == 8'h00) begin
            err_valid_q <= 1'b1;
            err_pos_q   <= pos_q;
            err_val_q   <= forney_e;
            roots_q     <= (roots_q == 2'd3) ? 2'd3 : roots_q + 2'd1;
          end
          t1_q  <= gf_mul_const(t1_q, ALPHA_INV);
          t2_q  <= gf_mul_const(t2_q, ALPHA_INV2);
          w1_q  <= gf_mul_const(w1_q, ALPHA_INV);
          x_q   <= gf_mul_const(x_q, ALPHA);
          pos_q <= pos_q + 8'd1;
          if (pos_q == LAST_POS) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q     <= 1'b1;
          err_cnt_q  <= roots_q;
          // inv1 is zero exactly when lambda1 is zero.
          dec_fail_q <= (roots_q != deg_q) || (lam0_q == 8'h00) ||
                        ((deg_q == 2'd2) && (inv1_q == 8'h00));
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign chien_busy = busy_q;
  assign err_valid  = err_valid_q;
  assign err_pos    = err_pos_q;
  assign err_val    = err_val_q;
  assign chien_done = done_q;
  assign err_cnt    = err_cnt_q;
  assign dec_fail   = dec_fail_q;

endmodule
